// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared state encoding for the FX2 loopback bridge
package fx2_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD       = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR       = 3'd4,
    ST_PK_SETUP = 3'd5,
    ST_PK       = 3'd6
  } fx2_state_e;

endpackage

// File: rtl/fx2_sync_fifo.sv
// rtl/fx2_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module fx2_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is accepted when the same edge frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fx2_loopback_bridge.sv
// rtl/fx2_loopback_bridge.sv - FX2 slave-FIFO master looping OUT endpoint data back to IN
module fx2_loopback_bridge
  import fx2_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         DEPTH       = 256,
  parameter int         PKT_LEN     = 256,
  parameter int         MAX_BURST   = 64,
  parameter int         IDLE_TO     = 64,
  parameter logic [1:0] OUT_EP_ADDR = 2'b00,
  parameter logic [1:0] IN_EP_ADDR  = 2'b10,
  localparam int        FILL_W      = $clog2(DEPTH) + 1
) (
  input  logic               USB_IFCLK,
  input  logic               RST,
  inout  wire  [DATA_W-1:0]  USB_DATA,
  output logic [1:0]         USB_ADDR,
  output logic               USB_SLOE,
  output logic               USB_SLRD,
  output logic               USB_SLWR,
  output logic               USB_PKEND,
  input  logic               USB_FLAGA,
  input  logic               USB_FLAGD,
  output logic [STATE_W-1:0] STATE,
  output logic [FILL_W-1:0]  FILL
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int PKT_W   = $clog2(PKT_LEN + 1);
  localparam int IDLE_W  = $clog2(IDLE_TO + 1);

  fx2_state_e        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;

  logic              full, empty;
  logic [FILL_W-1:0] fill;
  logic [DATA_W-1:0] head;
  logic              rd_beat, wr_beat, last_burst_beat, drive;

  assign rd_beat         = (state_q == ST_RD) && !full && USB_FLAGA;
  assign wr_beat         = (state_q == ST_WR) && !empty && USB_FLAGD;
  assign last_burst_beat = (burst_q == BURST_W'(MAX_BURST - 1));

  fx2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (USB_IFCLK),
    .rst_i       (RST),
    .push_i      (rd_beat && !RST),
    .push_data_i (USB_DATA),
    .pop_i       (wr_beat && !RST),
    .head_o      (head),
    .count_o     (fill),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    pkt_d   = pkt_q;
    idle_d  = '0;
    case (state_q)
      ST_IDLE: begin
        idle_d = (idle_q == IDLE_W'(IDLE_TO - 1)) ? idle_q : idle_q + 1'b1;
        // Drain first when half full or when the host has nothing more to send.
        if (!empty && USB_FLAGD && (fill >= FILL_W'(DEPTH / 2) || !USB_FLAGA))
          state_d = ST_WR_SETUP;
        else if (USB_FLAGA && !full)
          state_d = ST_RD_SETUP;
        else if (!empty && USB_FLAGD)
          state_d = ST_WR_SETUP;
        else if (pkt_q != '0 && empty && idle_q == IDLE_W'(IDLE_TO - 1))
          state_d = ST_PK_SETUP;
      end
      ST_RD_SETUP: begin
        burst_d = '0;
        state_d = ST_RD;
      end
      ST_RD: begin
        if (rd_beat) burst_d = burst_q + 1'b1;
        if (!USB_FLAGA || full ||
            (rd_beat && (fill == FILL_W'(DEPTH - 1) || last_burst_beat)))
          state_d = ST_IDLE;
      end
      ST_WR_SETUP: begin
        burst_d = '0;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (wr_beat) begin
          burst_d = burst_q + 1'b1;
          pkt_d   = (pkt_q == PKT_W'(PKT_LEN - 1)) ? '0 : pkt_q + 1'b1;
        end
        if (!USB_FLAGD || empty ||
            (wr_beat && (fill == FILL_W'(1) || last_burst_beat)))
          state_d = ST_IDLE;
      end
      ST_PK_SETUP: state_d = ST_PK;
      ST_PK: begin
        pkt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge USB_IFCLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      pkt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      pkt_q   <= pkt_d;
      idle_q  <= idle_d;
    end
  end

  // Bus and strobes depend only on registered state, never on the FX2 flags.
  assign drive     = (state_q == ST_WR_SETUP) || (state_q == ST_WR) ||
                     (state_q == ST_PK_SETUP) || (state_q == ST_PK);
  assign USB_DATA  = drive ? head : {DATA_W{1'bz}};
  assign USB_ADDR  = drive ? IN_EP_ADDR : OUT_EP_ADDR;
  assign USB_SLOE  = !((state_q == ST_RD_SETUP) || (state_q == ST_RD));
  assign USB_SLRD  = !((state_q == ST_RD) && !full);
  assign USB_SLWR  = !((state_q == ST_WR) && !empty);
  assign USB_PKEND = (state_q != ST_PK);
  assign STATE     = STATE_W'(state_q);
  assign FILL      = fill;

endmodule
